// File: rtl/mul_shift_add_seq_pkg.sv
// mul_shift_add_seq_pkg: shared state encoding and datapath width for the multiplier unit
package mul_shift_add_seq_pkg;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/fullbitadder.sv
// fullbitadder: 32-bit ripple-carry adder, carry-out discarded
module fullbitadder
  import mul_shift_add_seq_pkg::*;
(
  input  logic [DATA_W-1:0] d1,
  input  logic [DATA_W-1:0] d2,
  output logic [DATA_W-1:0] out
);
  logic c;
  always_comb begin
    c = 1'b0;
    out = '0;
    for (int i = 0; i < DATA_W; i++) begin
      out[i] = d1[i] ^ d2[i] ^ c;
      c = (d1[i] & d2[i]) | (c & (d1[i] ^ d2[i]));
    end
  end
endmodule

// File: rtl/mul_shift_add_seq.sv
// mul_shift_add_seq: sequential shift-add 32x32 multiplier (low word) with valid/ready handshakes
module mul_shift_add_seq
  import mul_shift_add_seq_pkg::*;
#(
  parameter int WIDTH      = DATA_W,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  state_t state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier, sum;
  logic [CW-1:0] cnt;
  logic last;
  fullbitadder u_add (.d1(acc), .d2(mcand), .out(sum));
  always_ff @(posedge clk) state <= rst ? ST_IDLE : state_nxt;
  always_comb begin
    last = (cnt == CW'(WIDTH - 1)) || (EARLY_EXIT && ((mplier >> 1) == '0));
    state_nxt = (state == ST_IDLE) ? (in_valid ? ST_RUN : ST_IDLE) :
                (state == ST_RUN)  ? (last ? ST_DONE : ST_RUN) :
                (state == ST_DONE) ? (out_ready ? ST_IDLE : ST_DONE) : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (state == ST_IDLE && in_valid) begin
      acc    <= '0;
      mcand  <= in_a;
      mplier <= in_b;
      cnt    <= '0;
    end else if (state == ST_RUN) begin
      acc    <= mplier[0] ? sum : acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
  always_comb begin
    in_ready   = (state == ST_IDLE);
    out_valid  = (state == ST_DONE);
    busy       = (state == ST_RUN) || (state == ST_DONE);
    out_result = acc;
  end
endmodule

// File: tb/tb_mul_shift_add_seq.sv
// tb_mul_shift_add_seq: randomized scoreboard bench for both early-exit settings
module tb_mul_shift_add_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid0 = 1'b0, out_ready0 = 1'b1, in_ready0, out_valid0, busy0;
  logic [31:0] in_a0 = '0, in_b0 = '0, out_result0;
  logic in_valid1 = 1'b0, out_ready1 = 1'b1, in_ready1, out_valid1, busy1;
  logic [31:0] in_a1 = '0, in_b1 = '0, out_result1;
  int checks = 0;
  int errors = 0;
  logic [31:0] q_res0[$], q_res1[$];
  int q_run0[$], q_run1[$];
  int run0 = 0, run1 = 0;

  always #5 clk = ~clk;

  mul_shift_add_seq #(.WIDTH(32), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_result(out_result0), .busy(busy0)
  );
  mul_shift_add_seq #(.WIDTH(32), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int run_len(input logic [31:0] b, input bit ee);
    if (!ee) return 32;
    for (int i = 31; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid0 && in_ready0) run0 = 0;
      else if (busy0 && !out_valid0) run0++;
      if (out_valid0 && out_ready0) begin
        if (q_res0.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out0: got 0x%08h expected no output", out_result0);
        end else begin
          check("result0", out_result0, q_res0.pop_front());
          check("run_cycles0", 32'(run0), 32'(q_run0.pop_front()));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid1 && in_ready1) run1 = 0;
      else if (busy1 && !out_valid1) run1++;
      if (out_valid1 && out_ready1) begin
        if (q_res1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out1: got 0x%08h expected no output", out_result1);
        end else begin
          check("result1", out_result1, q_res1.pop_front());
          check("run_cycles1", 32'(run1), 32'(q_run1.pop_front()));
        end
      end
    end
  end

  task automatic issue0(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready0) begin
      checks++;
      errors++;
      $display("FAIL issue0_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid0 = 1'b1;
    in_a0 = a;
    in_b0 = b;
    q_res0.push_back(a * b);
    q_run0.push_back(run_len(b, 1'b0));
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    in_a0 = $urandom;
    in_b0 = $urandom;
    check("busy_after_accept0", {31'b0, busy0}, 32'd1);
    check("in_ready_in_run0", {31'b0, in_ready0}, 32'd0);
  endtask

  task automatic issue1(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready1) begin
      checks++;
      errors++;
      $display("FAIL issue1_timeout: got in_ready=0 expected 1");
      return;
    end
    in_valid1 = 1'b1;
    in_a1 = a;
    in_b1 = b;
    q_res1.push_back(a * b);
    q_run1.push_back(run_len(b, 1'b1));
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    in_a1 = $urandom;
    in_b1 = $urandom;
    check("busy_after_accept1", {31'b0, busy1}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy0 || busy1) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy0=%0b busy1=%0b expected 0", busy0, busy1);
    end
  endtask

  initial begin
    logic [31:0] a, b, exp;
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready0", {31'b0, in_ready0}, 32'd1);
    check("reset_out_valid0", {31'b0, out_valid0}, 32'd0);
    check("reset_busy0", {31'b0, busy0}, 32'd0);
    check("reset_result0", out_result0, 32'd0);
    check("reset_in_ready1", {31'b0, in_ready1}, 32'd1);
    check("reset_result1", out_result1, 32'd0);
    issue0(32'd3, 32'd5);
    wait_idle();
    issue0(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    issue0(32'h0001_0000, 32'h0001_0000);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      issue0($urandom, (i % 2 == 0) ? $urandom : 32'($urandom_range(0, 255)));
      wait_idle();
    end
    out_ready0 = 1'b0;
    a = $urandom;
    b = $urandom;
    exp = a * b;
    issue0(a, b);
    n = 0;
    while (!out_valid0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      check("hold_valid0", {31'b0, out_valid0}, 32'd1);
      check("hold_result0", out_result0, exp);
      @(posedge clk); #1;
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    check("after_accept_valid0", {31'b0, out_valid0}, 32'd0);
    check("after_accept_ready0", {31'b0, in_ready0}, 32'd1);
    issue0(32'd11, 32'd13);
    repeat (5) @(posedge clk);
    #1;
    in_valid0 = 1'b1;
    in_a0 = 32'd7;
    in_b0 = 32'd9;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    wait_idle();
    repeat (40) @(posedge clk);
    #1;
    check("queue_drained0", 32'(q_res0.size()), 32'd0);
    issue0(32'd123456, 32'd789);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(q_res0.pop_back());
    void'(q_run0.pop_back());
    check("midrun_reset_ready0", {31'b0, in_ready0}, 32'd1);
    check("midrun_reset_valid0", {31'b0, out_valid0}, 32'd0);
    check("midrun_reset_busy0", {31'b0, busy0}, 32'd0);
    check("midrun_reset_result0", out_result0, 32'd0);
    issue0(32'd6, 32'd7);
    wait_idle();
    issue1(32'd5, 32'd1);
    wait_idle();
    issue1(32'd9, 32'd0);
    wait_idle();
    issue1(32'd3, 32'h8000_0000);
    wait_idle();
    issue1(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();
    for (int i = 0; i < 6; i++) begin
      issue1($urandom, $urandom >> $urandom_range(0, 31));
      wait_idle();
    end
    repeat (5) @(posedge clk);
    #1;
    check("queue_empty0", 32'(q_res0.size()), 32'd0);
    check("queue_empty1", 32'(q_res1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
